// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: next-PC/redirect controls, instruction-memory handshake and decode handoff.
// The fetch stage is the master; the environment (memory, next-PC logic, decode) is the slave.
interface pc_fetch_if #(
   parameter int unsigned PC_WIDTH    = 8,
   parameter int unsigned INSTR_WIDTH = 16
);
   logic [PC_WIDTH-1:0]    next_pc;
   logic                   redirect;
   logic [PC_WIDTH-1:0]    redirect_pc;
   logic                   halt;
   logic                   imem_req;
   logic [PC_WIDTH-1:0]    imem_addr;
   logic                   imem_ack;
   logic [INSTR_WIDTH-1:0] imem_rdata;
   logic                   if_valid;
   logic [INSTR_WIDTH-1:0] if_instr;
   logic [PC_WIDTH-1:0]    if_pc;
   logic                   id_ready;

   modport master (
      input  next_pc, redirect, redirect_pc, halt, imem_ack, imem_rdata, id_ready,
      output imem_req, imem_addr, if_valid, if_instr, if_pc
   );

   modport slave (
      output next_pc, redirect, redirect_pc, halt, imem_ack, imem_rdata, id_ready,
      input  imem_req, imem_addr, if_valid, if_instr, if_pc
   );
endinterface

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time and hands the
// returned instruction to decode, with redirect (flush), drain of stale requests and halt.
module pc_fetch_stage #(
   parameter int unsigned          PC_WIDTH    = 8,
   parameter int unsigned          INSTR_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
   input logic        clk,
   input logic        rst_n,
   pc_fetch_if.master bus
);

   typedef enum logic [1:0] {StReq, StValid, StDrain, StHalted} state_e;

   state_e                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [PC_WIDTH-1:0]    drain_addr_q, drain_addr_d;
   logic                   if_valid_q, if_valid_d;
   logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;
   logic [PC_WIDTH-1:0]    if_pc_q, if_pc_d;
   // Keeps imem_req low during reset and raises it on the first edge after release,
   // without a combinational path from rst_n to the request.
   logic                   go_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StReq;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         if_valid_q   <= 1'b0;
         if_instr_q   <= '0;
         if_pc_q      <= RESET_PC;
         go_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         if_valid_q   <= if_valid_d;
         if_instr_q   <= if_instr_d;
         if_pc_q      <= if_pc_d;
         go_q         <= 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      if_valid_d   = if_valid_q;
      if_instr_d   = if_instr_q;
      if_pc_d      = if_pc_q;

      unique case (state_q)
         StReq: begin
            if (!go_q) begin
               if (bus.redirect) pc_d = bus.redirect_pc;
            end else if (bus.redirect) begin
               pc_d = bus.redirect_pc;
               // Without the ack the old request is still in flight: finish it in DRAIN.
               if (!bus.imem_ack) begin
                  drain_addr_d = pc_q;
                  state_d      = StDrain;
               end
            end else if (bus.imem_ack) begin
               if_instr_d = bus.imem_rdata;
               if_pc_d    = pc_q;
               if_valid_d = 1'b1;
               state_d    = StValid;
            end
         end
         StValid: begin
            if (bus.redirect) begin
               pc_d       = bus.redirect_pc;
               if_valid_d = 1'b0;
               state_d    = StReq;
            end else if (bus.id_ready) begin
               pc_d       = bus.next_pc;
               if_valid_d = 1'b0;
               state_d    = bus.halt ? StHalted : StReq;
            end
         end
         StDrain: begin
            if (bus.redirect) pc_d = bus.redirect_pc;
            if (bus.imem_ack) state_d = StReq;
         end
         StHalted: begin
            if (bus.redirect) pc_d = bus.redirect_pc;
            if (!bus.halt) state_d = StReq;
         end
         default: state_d = StReq;
      endcase
   end

   assign bus.imem_req  = go_q && ((state_q == StReq) || (state_q == StDrain));
   assign bus.imem_addr = (state_q == StDrain) ? drain_addr_q : pc_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_instr  = if_instr_q;
   assign bus.if_pc     = if_pc_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: a latency-programmable memory model, a scoreboard of
// expected (pc, instr) pairs checked at every decode handoff, and direct output checks.
module tb_pc_fetch_stage;
   localparam int unsigned    PW     = 8;
   localparam int unsigned    IW     = 16;
   localparam logic [PW-1:0]  RST_PC = 8'h00;

   typedef struct packed {
      logic [PW-1:0] pc;
      logic [IW-1:0] instr;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pc_fetch_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

   pc_fetch_stage #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int            n_vec   = 0;
   int            n_err   = 0;
   int            lat     = 0;
   bit            stall   = 1'b0;
   bit            np_auto = 1'b1;
   logic [PW-1:0] np_val  = '0;
   int            cnt     = 0;
   exp_t          sb_q[$];

   function automatic logic [IW-1:0] dat(input logic [PW-1:0] a);
      return {~a, a};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [PW-1:0] pc);
      exp_t e;
      e.pc    = pc;
      e.instr = dat(pc);
      sb_q.push_back(e);
   endtask

   // Memory model and next-PC logic, updated away from the active edge.
   always @(negedge clk) begin
      bus.imem_rdata = dat(bus.imem_addr);
      if (!rst_n || !bus.imem_req) begin
         cnt          = 0;
         bus.imem_ack = 1'b0;
      end else begin
         if (bus.imem_ack) cnt = 0;
         bus.imem_ack = !stall && (cnt >= lat);
         cnt++;
      end
      bus.next_pc = np_auto ? bus.if_pc + PW'(1) : np_val;
   end

   // Scoreboard: every instruction accepted by decode must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.if_valid && bus.id_ready && !bus.redirect) begin
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            chk("sb_if_pc", 32'(bus.if_pc), 32'(e.pc));
            chk("sb_if_instr", 32'(bus.if_instr), 32'(e.instr));
         end
      end
   end

   initial begin
      bus.id_ready    = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.halt        = 1'b0;

      // Reset state
      repeat (2) tick();
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_valid", 32'(bus.if_valid), 32'd0);
      chk("rst_instr", 32'(bus.if_instr), 32'd0);
      chk("rst_if_pc", 32'(bus.if_pc), 32'(RST_PC));
      #2 rst_n = 1'b1;
      tick();
      chk("first_req", 32'(bus.imem_req), 32'd1);
      chk("first_addr", 32'(bus.imem_addr), 32'(RST_PC));

      // Single-cycle memory: sequential fetch at one instruction per two cycles
      for (int i = 0; i < 6; i++) begin
         chk("seq_req", 32'(bus.imem_req), 32'd1);
         chk("seq_addr", 32'(bus.imem_addr), 32'(i));
         push(PW'(i));
         tick();
         chk("seq_valid", 32'(bus.if_valid), 32'd1);
         chk("seq_req_low", 32'(bus.imem_req), 32'd0);
         tick();
      end

      // Ack after three wait cycles: address held for four cycles
      bus.id_ready = 1'b0;
      lat          = 3;
      for (int k = 0; k < 4; k++) begin
         chk("slow_req", 32'(bus.imem_req), 32'd1);
         chk("slow_addr", 32'(bus.imem_addr), 32'h06);
         chk("slow_valid", 32'(bus.if_valid), 32'd0);
         tick();
      end
      chk("slow_instr", 32'(bus.if_instr), 32'(dat(8'h06)));
      chk("slow_if_pc", 32'(bus.if_pc), 32'h06);

      // Decode stalls for five cycles, then a redirect wins over id_ready
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", 32'(bus.if_valid), 32'd1);
         chk("stall_req", 32'(bus.imem_req), 32'd0);
         chk("stall_instr", 32'(bus.if_instr), 32'(dat(8'h06)));
         tick();
      end
      bus.redirect    = 1'b1;
      bus.redirect_pc = 8'h40;
      bus.id_ready    = 1'b1;
      tick();
      bus.redirect = 1'b0;
      chk("redir_valid", 32'(bus.if_valid), 32'd0);
      chk("redir_req", 32'(bus.imem_req), 32'd1);
      chk("redir_addr", 32'(bus.imem_addr), 32'h40);

      // Redirect while a request to 10 is pending: drain it, then fetch the newest target
      lat     = 0;
      push(8'h40);
      np_auto = 1'b0;
      np_val  = 8'h10;
      tick();
      chk("pre_drain_pc", 32'(bus.if_pc), 32'h40);
      stall = 1'b1;
      tick();
      chk("pend_addr", 32'(bus.imem_addr), 32'h10);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 8'h70;
      tick();
      chk("drain_req", 32'(bus.imem_req), 32'd1);
      chk("drain_addr0", 32'(bus.imem_addr), 32'h10);
      bus.redirect_pc = 8'h80;
      tick();
      bus.redirect = 1'b0;
      chk("drain_addr1", 32'(bus.imem_addr), 32'h10);
      chk("drain_valid1", 32'(bus.if_valid), 32'd0);
      tick();
      chk("drain_addr2", 32'(bus.imem_addr), 32'h10);
      stall = 1'b0;
      tick();
      chk("post_drain_req", 32'(bus.imem_req), 32'd1);
      chk("post_drain_addr", 32'(bus.imem_addr), 32'h80);
      chk("post_drain_valid", 32'(bus.if_valid), 32'd0);
      np_auto = 1'b1;

      // Redirect in the same cycle as ack: data dropped, stays in REQ on the new target
      bus.redirect    = 1'b1;
      bus.redirect_pc = 8'h20;
      tick();
      bus.redirect = 1'b0;
      chk("racc_req", 32'(bus.imem_req), 32'd1);
      chk("racc_addr", 32'(bus.imem_addr), 32'h20);
      chk("racc_valid", 32'(bus.if_valid), 32'd0);

      // Halt raised during REQ: instruction still completes, halt honoured on acceptance
      bus.halt = 1'b1;
      lat      = 2;
      push(8'h20);
      tick();
      chk("halt_req0", 32'(bus.imem_req), 32'd1);
      tick();
      chk("halt_addr1", 32'(bus.imem_addr), 32'h20);
      tick();
      chk("halt_valid", 32'(bus.if_valid), 32'd1);
      tick();
      chk("halted_req", 32'(bus.imem_req), 32'd0);
      chk("halted_valid", 32'(bus.if_valid), 32'd0);
      tick();
      chk("halted_req2", 32'(bus.imem_req), 32'd0);
      bus.halt = 1'b0;
      tick();
      chk("resume_req", 32'(bus.imem_req), 32'd1);
      chk("resume_addr", 32'(bus.imem_addr), 32'h21);

      // Asynchronous reset in the middle of DRAIN
      stall           = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 8'h50;
      tick();
      bus.redirect = 1'b0;
      chk("d2_addr", 32'(bus.imem_addr), 32'h21);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_req", 32'(bus.imem_req), 32'd0);
      chk("arst_valid", 32'(bus.if_valid), 32'd0);
      chk("arst_if_pc", 32'(bus.if_pc), 32'(RST_PC));
      chk("arst_instr", 32'(bus.if_instr), 32'd0);
      chk("arst_addr", 32'(bus.imem_addr), 32'(RST_PC));
      stall = 1'b0;
      lat   = 0;
      tick();
      chk("arst_req_hold", 32'(bus.imem_req), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      chk("rel_req", 32'(bus.imem_req), 32'd1);
      chk("rel_addr", 32'(bus.imem_addr), 32'(RST_PC));

      // PC wraps from FF to 00
      bus.redirect    = 1'b1;
      bus.redirect_pc = 8'hFF;
      tick();
      bus.redirect = 1'b0;
      chk("wrap_addr_ff", 32'(bus.imem_addr), 32'hFF);
      push(8'hFF);
      tick();
      chk("wrap_if_pc", 32'(bus.if_pc), 32'hFF);
      tick();
      chk("wrap_req", 32'(bus.imem_req), 32'd1);
      chk("wrap_addr_00", 32'(bus.imem_addr), 32'h00);
      push(8'h00);
      tick();
      tick();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
